stopwatch_bcd_counter: RTL and testbench

//  Timebase and four-digit BCD counter chain for the stopwatch, MM:SS range 00:00..59:59.

---
 rtl/stopwatch_bcd_counter_pkg.sv | 17 +
 rtl/stopwatch_bcd_counter_digit.sv | 38 +++
 rtl/stopwatch_bcd_counter.sv | 137 +++++++++++++
 tb/tb_stopwatch_bcd_counter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_bcd_counter_pkg.sv
// Shared types and digit limits for the stopwatch timebase and BCD counter chain.
package stopwatch_pkg;

   typedef logic [3:0] bcd_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } sw_state_e;

   localparam bcd_t SEC_ONES_MAX = 4'd9;
   localparam bcd_t SEC_TENS_MAX = 4'd5;
   localparam bcd_t MIN_ONES_MAX = 4'd9;
   localparam bcd_t MIN_TENS_MAX = 4'd5;

endpackage

// File: rtl/stopwatch_bcd_counter_digit.sv
// Single BCD digit counter: counts 0..MAX on inc, wraps to 0 and flags carry.
module bcd_digit_counter
   import stopwatch_pkg::*;
#(
   parameter bcd_t MAX = 4'd9
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output bcd_t q,
   output logic carry
);

   bcd_t q_q;
   bcd_t q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (inc) begin
         q_d = (q_q >= MAX) ? '0 : q_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q     = q_q;
   assign carry = inc && (q_q == MAX);

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch timebase: one-second prescaler, start/pause/clear FSM and MM:SS BCD chain.
// Optional lap freeze of the displayed digits is built when STOPWATCH_LAP_EN is defined.
//
// state | meaning
// IDLE  | cleared, prescaler held at 0, digits 00:00
// RUN   | prescaler counting, digits advance once per TICK_DIV cycles
// PAUSE | prescaler and digits hold, fractional second kept for resume
module stopwatch_bcd_counter
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICK_DIV = 100_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start_stop,
   input  logic clear,
   input  logic lap,
   output bcd_t sec_ones,
   output bcd_t sec_tens,
   output bcd_t min_ones,
   output bcd_t min_tens,
   output logic running,
   output logic rollover
);

   localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   sw_state_e     state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          running_q, running_d;
   logic          rollover_q, rollover_d;
   logic          tick;

   bcd_t so_q, st_q, mo_q, mt_q;
   logic so_carry, st_carry, mo_carry, mt_carry;
   logic [15:0] live;

   assign tick = (state_q == RUN) && (presc_q == PRESC_MAX);

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      case (state_q)
         IDLE: begin
            presc_d = '0;
            if (start_stop) state_d = RUN;
         end
         RUN: begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (start_stop) state_d = PAUSE;
         end
         PAUSE: begin
            if (start_stop) state_d = RUN;
         end
         default: begin
            state_d = IDLE;
            presc_d = '0;
         end
      endcase
      // clear wins over any start/pause request in the same cycle
      if (clear) begin
         state_d = IDLE;
         presc_d = '0;
      end
   end

   always_comb begin
      running_d  = (state_d == RUN);
      rollover_d = mt_carry && !clear;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         presc_q    <= '0;
         running_q  <= 1'b0;
         rollover_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         running_q  <= running_d;
         rollover_q <= rollover_d;
      end
   end

   bcd_digit_counter #(.MAX(SEC_ONES_MAX)) u_sec_ones (
      .clk(clk), .rst_n(rst_n), .clr(clear), .inc(tick),     .q(so_q), .carry(so_carry)
   );
   bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
      .clk(clk), .rst_n(rst_n), .clr(clear), .inc(so_carry), .q(st_q), .carry(st_carry)
   );
   bcd_digit_counter #(.MAX(MIN_ONES_MAX)) u_min_ones (
      .clk(clk), .rst_n(rst_n), .clr(clear), .inc(st_carry), .q(mo_q), .carry(mo_carry)
   );
   bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
      .clk(clk), .rst_n(rst_n), .clr(clear), .inc(mo_carry), .q(mt_q), .carry(mt_carry)
   );

   assign live = {mt_q, mo_q, st_q, so_q};

`ifdef STOPWATCH_LAP_EN
   logic        frz_q, frz_d;
   logic [15:0] snap_q, snap_d;

   always_comb begin
      frz_d  = frz_q;
      snap_d = snap_q;
      if (clear) begin
         frz_d = 1'b0;
      end else if (lap && (state_q != IDLE)) begin
         frz_d = !frz_q;
         if (!frz_q) snap_d = live;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frz_q  <= 1'b0;
         snap_q <= '0;
      end else begin
         frz_q  <= frz_d;
         snap_q <= snap_d;
      end
   end

   assign {min_tens, min_ones, sec_tens, sec_ones} = frz_q ? snap_q : live;
`else
   logic lap_unused;
   assign lap_unused = lap;
   assign {min_tens, min_ones, sec_tens, sec_ones} = live;
`endif

   assign running  = running_q;
   assign rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench for stopwatch_bcd_counter with TICK_DIV=4; digits compared as a packed MM:SS hex word.
module tb_stopwatch_bcd_counter;

   logic       clk;
   logic       rst_n;
   logic       start_stop;
   logic       clear;
   logic       lap;
   logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
   logic       running;
   logic       rollover;
   logic [15:0] dig;

   int checks;
   int failures;

   stopwatch_bcd_counter #(.TICK_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clear(clear), .lap(lap),
      .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
      .running(running), .rollover(rollover)
   );

   assign dig = {min_tens, min_ones, sec_tens, sec_ones};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_ss();
      start_stop = 1'b1;
      @(negedge clk);
      start_stop = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic pulse_lap();
      lap = 1'b1;
      @(negedge clk);
      lap = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
      #1;
      checks++;
      if (dig !== 16'h0000 || running !== 1'b0 || rollover !== 1'b0) begin
         $display("FAIL reset_state: dig=%h run=%b roll=%b want 0000/0/0", dig, running, rollover);
         failures++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(3);
      checks++;
      if (dig !== 16'h0000 || running !== 1'b0) begin
         $display("FAIL reset_idle_hold: dig=%h run=%b want 0000/0", dig, running);
         failures++;
      end
   endtask

   task automatic test_count();
      pulse_ss();
      checks++;
      if (running !== 1'b1) begin
         $display("FAIL count_running: got %b want 1", running);
         failures++;
      end
      step(3);
      checks++;
      if (dig !== 16'h0000) begin
         $display("FAIL count_before_first_tick: got %h want 0000", dig);
         failures++;
      end
      step(1);
      checks++;
      if (dig !== 16'h0001) begin
         $display("FAIL count_first_tick: got %h want 0001", dig);
         failures++;
      end
      step(36);
      checks++;
      if (dig !== 16'h0010 || running !== 1'b1) begin
         $display("FAIL count_40clk: dig=%h run=%b want 0010/1", dig, running);
         failures++;
      end
   endtask

   task automatic test_pause();
      int bad;
      pulse_clear();
      pulse_ss();
      step(1);
      pulse_ss();
      checks++;
      if (running !== 1'b0) begin
         $display("FAIL pause_running: got %b want 0", running);
         failures++;
      end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (dig !== 16'h0000) bad++;
      end
      checks++;
      if (bad != 0 || dig !== 16'h0000) begin
         $display("FAIL pause_frozen: %0d moving cycles, dig=%h want 0000", bad, dig);
         failures++;
      end
      pulse_ss();
      checks++;
      if (running !== 1'b1 || dig !== 16'h0000) begin
         $display("FAIL resume_entry: dig=%h run=%b want 0000/1", dig, running);
         failures++;
      end
      step(1);
      checks++;
      if (dig !== 16'h0000) begin
         $display("FAIL resume_1clk: got %h want 0000", dig);
         failures++;
      end
      step(1);
      checks++;
      if (dig !== 16'h0001) begin
         $display("FAIL resume_2clk: got %h want 0001", dig);
         failures++;
      end
   endtask

   task automatic test_rollover();
      int roll_seen;
      pulse_clear();
      pulse_ss();
      roll_seen = 0;
      for (int i = 0; i < 3598 * 4; i++) begin
         step(1);
         if (rollover !== 1'b0) roll_seen++;
         if (sec_ones > 4'd9 || sec_tens > 4'd5 || min_ones > 4'd9 || min_tens > 4'd5) roll_seen++;
      end
      checks++;
      if (dig !== 16'h5958 || roll_seen != 0) begin
         $display("FAIL roll_preload: dig=%h bad=%0d want 5958/0", dig, roll_seen);
         failures++;
      end
      step(4);
      checks++;
      if (dig !== 16'h5959 || rollover !== 1'b0) begin
         $display("FAIL roll_5959: dig=%h roll=%b want 5959/0", dig, rollover);
         failures++;
      end
      step(4);
      checks++;
      if (dig !== 16'h0000 || rollover !== 1'b1) begin
         $display("FAIL roll_wrap: dig=%h roll=%b want 0000/1", dig, rollover);
         failures++;
      end
      step(1);
      checks++;
      if (rollover !== 1'b0) begin
         $display("FAIL roll_one_cycle: got %b want 0", rollover);
         failures++;
      end
      step(3);
      checks++;
      if (dig !== 16'h0001 || running !== 1'b1) begin
         $display("FAIL roll_continue: dig=%h run=%b want 0001/1", dig, running);
         failures++;
      end
   endtask

   task automatic test_clear_priority();
      clear = 1'b1;
      start_stop = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      start_stop = 1'b0;
      checks++;
      if (dig !== 16'h0000 || running !== 1'b0) begin
         $display("FAIL clear_prio: dig=%h run=%b want 0000/0", dig, running);
         failures++;
      end
      step(8);
      checks++;
      if (dig !== 16'h0000 || running !== 1'b0) begin
         $display("FAIL clear_idle_stays: dig=%h run=%b want 0000/0", dig, running);
         failures++;
      end
   endtask

   task automatic test_lap();
      logic [15:0] exp_hold;
      `ifdef STOPWATCH_LAP_EN
      exp_hold = 16'h0005;
      `else
      exp_hold = 16'h0010;
      `endif
      pulse_clear();
      pulse_lap();
      pulse_ss();
      step(4);
      checks++;
      if (dig !== 16'h0001) begin
         $display("FAIL lap_idle_ignored: got %h want 0001", dig);
         failures++;
      end
      pulse_clear();
      pulse_ss();
      step(20);
      checks++;
      if (dig !== 16'h0005) begin
         $display("FAIL lap_pre: got %h want 0005", dig);
         failures++;
      end
      pulse_lap();
      step(19);
      checks++;
      if (dig !== exp_hold || running !== 1'b1) begin
         $display("FAIL lap_hold: dig=%h run=%b want %h/1", dig, running, exp_hold);
         failures++;
      end
      pulse_lap();
      checks++;
      if (dig !== 16'h0010) begin
         $display("FAIL lap_release: got %h want 0010", dig);
         failures++;
      end
   endtask

   task automatic test_reset_mid();
      pulse_clear();
      pulse_ss();
      step(754 * 4);
      checks++;
      if (dig !== 16'h1234) begin
         $display("FAIL mid_preload: got %h want 1234", dig);
         failures++;
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (dig !== 16'h0000 || running !== 1'b0 || rollover !== 1'b0) begin
         $display("FAIL mid_async_reset: dig=%h run=%b roll=%b want 0000/0/0", dig, running, rollover);
         failures++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(8);
      checks++;
      if (dig !== 16'h0000 || running !== 1'b0) begin
         $display("FAIL mid_after_release: dig=%h run=%b want 0000/0", dig, running);
         failures++;
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_count();
      test_pause();
      test_rollover();
      test_clear_priority();
      test_lap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
